// File: rtl/sa_arbiter.sv
// Round-robin arbiter sharing one systolic array between two matrix-multiply requesters.
// Launches one job at a time, muxes the winner's operands and routes the result back.
module sa_arbiter #(
    parameter int D_W         = 8,
    parameter int SA_R        = 16,
    parameter int SA_C        = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      I_CLK,
    input  logic                      I_RST_N,
    input  logic [1:0]                I_REQ,
    input  logic [D_W*SA_R*SA_C-1:0]  I_MAT_1_0,
    input  logic [D_W*SA_R*SA_C-1:0]  I_MAT_1_1,
    input  logic [D_W*SA_R*SA_C-1:0]  I_MAT_2_0,
    input  logic [D_W*SA_R*SA_C-1:0]  I_MAT_2_1,
    input  logic [D_W*SA_R*SA_C-1:0]  I_DATA_LOAD_0,
    input  logic [D_W*SA_R*SA_C-1:0]  I_DATA_LOAD_1,
    output logic [1:0]                O_GNT,
    output logic [1:0]                O_VLD,
    output logic [D_W*SA_R*SA_C-1:0]  O_RESULT,
    output logic [1:0]                O_PE_SHIFT,
    output logic                      O_TIMEOUT,
    output logic                      O_SA_START,
    output logic [D_W*SA_R*SA_C-1:0]  O_MAT_1,
    output logic [D_W*SA_R*SA_C-1:0]  O_MAT_2,
    output logic [D_W*SA_R*SA_C-1:0]  O_DATA_LOAD,
    input  logic                      I_SA_VLD,
    input  logic [D_W*SA_R*SA_C-1:0]  I_SA_RESULT,
    input  logic                      I_PE_SHIFT
);

    localparam int MW    = D_W * SA_R * SA_C;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vld_q, vld_d;
    logic             tmo_q, tmo_d;
    logic [MW-1:0]    result_q, result_d;
    logic             active;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            vld_q    <= 2'b00;
            tmo_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        vld_d    = 2'b00;
        tmo_d    = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (|I_REQ) begin
                    // On a tie the requester not served last wins.
                    sel_d   = (I_REQ == 2'b11) ? ~last_q : I_REQ[1];
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // A result on the terminal-count cycle takes priority over the abort.
                if (I_SA_VLD) begin
                    result_d = I_SA_RESULT;
                    vld_d    = sel_q ? 2'b10 : 2'b01;
                    last_d   = sel_q;
                    state_d  = IDLE;
                end else if (TIMEOUT_CYC != 0 && cnt_q == TERM) begin
                    tmo_d   = 1'b1;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active      = (state_q != IDLE);
    assign O_GNT       = active ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign O_SA_START  = (state_q == START);
    assign O_VLD       = vld_q;
    assign O_TIMEOUT   = tmo_q;
    assign O_RESULT    = result_q;
    assign O_PE_SHIFT  = {2{I_PE_SHIFT}} & O_GNT;
    assign O_MAT_1     = !active ? '0 : (sel_q ? I_MAT_1_1 : I_MAT_1_0);
    assign O_MAT_2     = !active ? '0 : (sel_q ? I_MAT_2_1 : I_MAT_2_0);
    assign O_DATA_LOAD = !active ? '0 : (sel_q ? I_DATA_LOAD_1 : I_DATA_LOAD_0);

endmodule
